// File: rtl/multichannel_input_conditioner_if.sv
// Bundle of the pin-side and logic-side signals of the multichannel input conditioner.
//   noisysignal  raw asynchronous inputs, one per channel
//   enable       per-channel requalification enable (synchronous)
//   conditioned  debounced, synchronised level per channel
//   positiveedge one-cycle pulse on a 0->1 change of conditioned
//   negativeedge one-cycle pulse on a 1->0 change of conditioned
//   anyedge      OR of all edge pulses, aligned with them
// master: the side that drives the pins (system or bench); slave: the conditioner.
interface multichannel_input_conditioner_if #(
  parameter int unsigned CHANNELS = 4
) ();
  logic [CHANNELS-1:0] noisysignal;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] conditioned;
  logic [CHANNELS-1:0] positiveedge;
  logic [CHANNELS-1:0] negativeedge;
  logic                anyedge;

  modport master (
    output noisysignal,
    output enable,
    input  conditioned,
    input  positiveedge,
    input  negativeedge,
    input  anyedge
  );

  modport slave (
    input  noisysignal,
    input  enable,
    output conditioned,
    output positiveedge,
    output negativeedge,
    output anyedge
  );
endinterface

// File: rtl/multichannel_input_conditioner.sv
// Multichannel input conditioner: per channel, optional inversion, a SYNCSTAGES-deep synchroniser,
// a debouncer that accepts a new level only after WAITTIME+1 consecutive differing samples, and
// single-cycle rising/falling edge pulses. anyedge flags a pulse on any channel in the same cycle.
// Ports:
//   clk_i    system clock, all state on posedge
//   reset_i  synchronous active-high reset
//   bus      slave side of multichannel_input_conditioner_if (inputs, enables, outputs)
module multichannel_input_conditioner #(
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         SYNCSTAGES   = 2,
  parameter int unsigned         COUNTERWIDTH = 5,
  parameter int unsigned         WAITTIME     = 10,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  multichannel_input_conditioner_if.slave bus
);

  localparam logic [COUNTERWIDTH-1:0] WaitCnt = COUNTERWIDTH'(WAITTIME);
  localparam logic [COUNTERWIDTH-1:0] CntOne  = COUNTERWIDTH'(1);

  // Power-up values match the reset values.
  logic [CHANNELS-1:0][SYNCSTAGES-1:0]   sync_q  = '0;
  logic [CHANNELS-1:0][SYNCSTAGES-1:0]   sync_d;
  logic [CHANNELS-1:0][COUNTERWIDTH-1:0] count_q = '0;
  logic [CHANNELS-1:0][COUNTERWIDTH-1:0] count_d;
  logic [CHANNELS-1:0]                   cond_q  = '0;
  logic [CHANNELS-1:0]                   cond_d;
  logic [CHANNELS-1:0]                   pos_q   = '0;
  logic [CHANNELS-1:0]                   pos_d;
  logic [CHANNELS-1:0]                   neg_q   = '0;
  logic [CHANNELS-1:0]                   neg_d;
  logic                                  any_q   = 1'b0;
  logic                                  any_d;

  always_comb begin
    sync_d  = sync_q;
    count_d = '0;
    cond_d  = cond_q;
    pos_d   = '0;
    neg_d   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNCSTAGES-2:0], bus.noisysignal[i] ^ INVERT[i]};
      // The last synchroniser stage is the sample the debouncer judges this cycle.
      if (!bus.enable[i]) begin
        // Frozen: level held, any count in progress dropped.
      end else if (sync_q[i][SYNCSTAGES-1] == cond_q[i]) begin
        // Input agrees with the accepted level: a glitch, if any, is over.
      end else if (count_q[i] == WaitCnt) begin
        cond_d[i] = sync_q[i][SYNCSTAGES-1];
        pos_d[i]  = sync_q[i][SYNCSTAGES-1];
        neg_d[i]  = ~sync_q[i][SYNCSTAGES-1];
      end else begin
        count_d[i] = count_q[i] + CntOne;
      end
    end
    any_d = |(pos_d | neg_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      count_q <= '0;
      cond_q  <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
      cond_q  <= cond_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      any_q   <= any_d;
    end
  end

  assign bus.conditioned  = cond_q;
  assign bus.positiveedge = pos_q;
  assign bus.negativeedge = neg_q;
  assign bus.anyedge      = any_q;

endmodule
